// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared types and the rotating priority search used by the
// multi-port SDRAM arbiter.
package sdram_arb_pkg;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  localparam int unsigned ARB_MAX_PORTS = 8;
  localparam int unsigned ARB_IDX_W     = 3;

  typedef struct packed {
    logic                 found;
    logic [ARB_IDX_W-1:0] idx;
  } arb_pick_t;

  // First requesting port at or after 'start', wrapping at num_ports-1 -> 0.
  // Fixed priority is the same search started from port 0.
  function automatic arb_pick_t arb_rotate_pick(
    input logic [ARB_MAX_PORTS-1:0] req,
    input logic [ARB_IDX_W-1:0]     start,
    input int unsigned              num_ports
  );
    arb_pick_t   pick;
    int unsigned cand;
    pick = '0;
    for (int unsigned i = 0; i < ARB_MAX_PORTS; i++) begin
      cand = (32'(start) + i) % num_ports;
      if ((i < num_ports) && !pick.found && req[cand[ARB_IDX_W-1:0]]) begin
        pick.found = 1'b1;
        pick.idx   = cand[ARB_IDX_W-1:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// sdram_arb_tag_fifo: in-order FIFO of port ids for requests in flight.
// Push and pop may coincide at any occupancy, including full.
module sdram_arb_tag_fifo
  import sdram_arb_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  // Qualify push/pop and compute next pointers and occupancy.
  always_comb begin
    do_pop   = pop_i & (count_q != '0);
    do_push  = push_i & ((count_q != (PTR_W+1)'(DEPTH)) | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Tag storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/sdram_arb_multi.sv
// sdram_arb_multi: N-port request/ack arbiter in front of the sdram32 core.
// Round-robin or fixed priority, grant lock while the core stalls, and an
// in-order tag FIFO that routes responses back to the issuing port.
// Optional: define SDRAM_ARB_STATS_EN for per-port saturating accept counters.
module sdram_arb_multi
  import sdram_arb_pkg::*;
#(
  parameter int NUM_PORTS       = 4,
  parameter int ARB_MODE        = 0,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NUM_PORTS-1:0][DATA_W/8-1:0]    port_wr_i,
  input  logic [NUM_PORTS-1:0]                  port_rd_i,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]      port_addr_i,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]      port_write_data_i,
  output logic [NUM_PORTS-1:0]                  port_accept_o,
  output logic [NUM_PORTS-1:0]                  port_ack_o,
  output logic [NUM_PORTS-1:0]                  port_error_o,
  output logic [NUM_PORTS-1:0][DATA_W-1:0]      port_read_data_o,
  output logic [DATA_W/8-1:0]                   core_wr_o,
  output logic                                  core_rd_o,
  output logic [ADDR_W-1:0]                     core_addr_o,
  output logic [DATA_W-1:0]                     core_write_data_o,
  input  logic                                  core_accept_i,
  input  logic                                  core_ack_i,
  input  logic                                  core_error_i,
  input  logic [DATA_W-1:0]                     core_read_data_i,
  output logic                                  spurious_ack_o
`ifdef SDRAM_ARB_STATS_EN
  ,
  input  logic                                  stats_clear_i,
  output logic [NUM_PORTS-1:0][31:0]            stats_accept_count_o
`endif
);

  localparam int ID_W  = $clog2(NUM_PORTS);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  arb_state_e               state_q, state_d;
  logic [ID_W-1:0]          lock_id_q, lock_id_d;
  logic [ID_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [NUM_PORTS-1:0]     req;
  logic [ARB_MAX_PORTS-1:0] req_pad;
  logic [ARB_IDX_W-1:0]     arb_start;
  arb_pick_t                pick;
  logic                     grant_valid;
  logic [ID_W-1:0]          grant_id;
  logic                     ack_hit, tag_space, drive, accept_fire;
  logic [ID_W-1:0]          fifo_head;
  logic                     fifo_full, fifo_empty;
  logic [CNT_W-1:0]         fifo_count;

  // Per-port request decode and arbitration; a locked grant overrides the search.
  always_comb begin
    req     = '0;
    req_pad = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      req[p] = (|port_wr_i[p]) | port_rd_i[p];
    end
    req_pad[NUM_PORTS-1:0] = req;
    arb_start = (ARB_MODE == int'(ARB_FIXED)) ? '0 : ARB_IDX_W'(rr_ptr_q);
    pick      = arb_rotate_pick(req_pad, arb_start, unsigned'(NUM_PORTS));
    if (state_q == ST_LOCKED) begin
      grant_valid = 1'b1;
      grant_id    = lock_id_q;
    end else begin
      grant_valid = pick.found;
      grant_id    = ID_W'(pick.idx);
    end
    // An ack in the same cycle frees a slot, so a full FIFO can still accept.
    ack_hit     = core_ack_i & (fifo_count != '0) & ~rst_i;
    tag_space   = ~fifo_full | ack_hit;
    drive       = grant_valid & tag_space & ~rst_i;
    accept_fire = drive & core_accept_i;
  end

  // Next-state: lock onto a winner the core did not take; rotate pointer on accept.
  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    rr_ptr_d  = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid && !accept_fire) begin
          state_d   = ST_LOCKED;
          lock_id_d = grant_id;
        end
      end
      ST_LOCKED: begin
        if (accept_fire) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept_fire && (ARB_MODE != int'(ARB_FIXED))) begin
      rr_ptr_d = (grant_id == ID_W'(NUM_PORTS - 1)) ? '0 : grant_id + 1'b1;
    end
  end

  // Arbiter control registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      lock_id_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  sdram_arb_tag_fifo #(
    .WIDTH (ID_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (accept_fire),
    .data_i  (grant_id),
    .pop_i   (ack_hit),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Core-side mux from the grant and response routing to the FIFO head port.
  always_comb begin
    core_wr_o         = '0;
    core_rd_o         = 1'b0;
    core_addr_o       = '0;
    core_write_data_o = '0;
    port_accept_o     = '0;
    port_ack_o        = '0;
    port_error_o      = '0;
    port_read_data_o  = '0;
    spurious_ack_o    = core_ack_i & fifo_empty & ~rst_i;
    if (drive) begin
      core_wr_o         = port_wr_i[grant_id];
      core_rd_o         = port_rd_i[grant_id];
      core_addr_o       = port_addr_i[grant_id];
      core_write_data_o = port_write_data_i[grant_id];
    end
    if (accept_fire) port_accept_o[grant_id] = 1'b1;
    if (ack_hit) begin
      port_ack_o[fifo_head]   = 1'b1;
      port_error_o[fifo_head] = core_error_i;
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_read_data_o[p] = rst_i ? '0 : core_read_data_i;
    end
  end

`ifdef SDRAM_ARB_STATS_EN
  logic [NUM_PORTS-1:0][31:0] stats_cnt_q, stats_cnt_d;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Per-port accept counters; clear beats a same-cycle increment.
  always_comb begin
    stats_cnt_d = stats_cnt_q;
    if (stats_clear_i) begin
      stats_cnt_d = '0;
    end else if (accept_fire) begin
      stats_cnt_d[grant_id] = sat_inc32(stats_cnt_q[grant_id]);
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) stats_cnt_q <= '0;
    else       stats_cnt_q <= stats_cnt_d;
  end

  assign stats_accept_count_o = stats_cnt_q;
`endif

endmodule

// File: doc/sdram_arb_multi.md
Name: sdram_arb_multi

Overview:
- Parametrised N-port arbiter that multiplexes NUM_PORTS request/ack RAM ports onto the single sdram32 core port.
- Successor to the fixed two-port arbiter used in the dual-port SDRAM top level.
- Adds selectable round-robin or fixed-priority arbitration, a grant lock while the core stalls, and an in-order tag FIFO that routes ack/error/read data back to the issuing port with up to MAX_OUTSTANDING requests in flight.

Parameters:
- NUM_PORTS, 4: number of requesting ports (2..8).
- ARB_MODE, 0: 0 = round-robin, 1 = fixed priority (port 0 highest).
- MAX_OUTSTANDING, 4: tag FIFO depth (power of 2, ≥2).
- ADDR_W, 32: address width.
- DATA_W, 32: data width; strobe width is DATA_W/8.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- port_wr_i  in  [NUM_PORTS][DATA_W/8]  per-port byte write strobes
- port_rd_i  in  [NUM_PORTS]  per-port read request
- port_addr_i  in  [NUM_PORTS][ADDR_W]  per-port address
- port_write_data_i  in  [NUM_PORTS][DATA_W]  per-port write data
- port_accept_o  out  [NUM_PORTS]  request taken this cycle
- port_ack_o  out  [NUM_PORTS]  response for the oldest accepted request of that port
- port_error_o  out  [NUM_PORTS]  error, qualified by ack
- port_read_data_o  out  [NUM_PORTS][DATA_W]  read data, qualified by ack
- core_wr_o  out  DATA_W/8  to core
- core_rd_o  out  1  to core
- core_addr_o  out  ADDR_W  to core
- core_write_data_o  out  DATA_W  to core
- core_accept_i  in  1  core took the request
- core_ack_i  in  1  core response valid
- core_error_i  in  1  core error
- core_read_data_i  in  DATA_W  core read data
- spurious_ack_o  out  1  one-cycle pulse: core_ack_i arrived with tag FIFO empty

Behaviour:
- Port request: req[p] = |port_wr_i[p] | port_rd_i[p].
  - A port holds addr, data, wr and rd stable until it sees port_accept_o.
  - wr and rd are never asserted together.
- States:
  - IDLE: winner = arbitrate(req) combinationally; core_* driven from winner in the same cycle (zero-cycle path).
    - core_accept_i=1 → stay IDLE.
    - core_accept_i=0 with req≠0 → LOCKED, lock_id=winner.
  - LOCKED: core_* driven from lock_id only; other requests ignored.
    - core_accept_i=1 → IDLE.
- port_accept_o[g] = core_accept_i for granted port g and tag FIFO not full; 0 for all other ports.
- No grant, or FIFO full: core_wr_o=0, core_rd_o=0, core_addr_o/core_write_data_o=0.
  - FIFO full while LOCKED: stay LOCKED with outputs suppressed until space frees.
- Round-robin:
  - rr_ptr reset 0.
  - Search starts at rr_ptr, wrapping NUM_PORTS-1 → 0.
  - On each accepted request, rr_ptr = (granted+1) mod NUM_PORTS.
- Fixed priority: lowest-index requesting port wins; rr_ptr unused.
- Tag FIFO, width $clog2(NUM_PORTS):
  - Push granted id on accept; pop on core_ack_i.
  - Simultaneous push and pop allowed at any occupancy, including full: count unchanged.
- Ack routing:
  - port_ack_o[head]=core_ack_i.
  - port_error_o[head]=core_error_i & core_ack_i.
  - Read data fans out to all ports unqualified; consumers qualify with ack.
- Ack with FIFO empty: no port ack, spurious_ack_o=1 for one cycle, FIFO unchanged.
- Reset values:
  - All outputs 0, state IDLE, rr_ptr 0, FIFO empty.
  - Reset mid-operation discards in-flight tags; the core is reset by the same domain.

Optional Feature:
- SDRAM_ARB_STATS_EN defined:
  - Adds output stats_accept_count_o [NUM_PORTS][32]: per-port accepted-request counters, saturating at 0xFFFF_FFFF.
  - Adds input stats_clear_i: synchronous clear; wins over a same-cycle increment.
  - Counters reset to 0.
- SDRAM_ARB_STATS_EN undefined: those ports and counters do not exist; behaviour otherwise identical.

Decomposition:
- Package sdram_arb_pkg:
  - arb_mode_e (ARB_RR=0, ARB_FIXED=1).
  - State enum (IDLE, LOCKED).
  - Function for the rotating priority search.
- Sub-module sdram_arb_tag_fifo (parametrised width/depth, full/empty/count) holds the port-id FIFO.

Test Plan:
- NUM_PORTS=4, RR, ports 0..3 read every cycle, core_accept_i=1 → grants 0,1,2,3,0…; each port gets exactly 1 of every 4 accepts.
- ARB_MODE=1, ports 1 and 3 requesting → port 1 always granted; port 3 granted only after port 1 deasserts.
- Port 2 writes addr 0x100, wr=0xF, with core_accept_i low 3 cycles while port 0 raises a request → core_addr_o stays 0x100 and lock_id stays 2; port 2 accepted on cycle 4.
- MAX_OUTSTANDING=4, issue 4 reads from ports 3,1,0,1 with no acks → 5th request suppressed; acks return in order to ports 3,1,0,1 with read data 0xA0..0xA3; an ack plus a new accept in the same cycle while full is accepted.
- core_ack_i pulsed with FIFO empty → spurious_ack_o=1 for one cycle, no port_ack_o.
- rst_i asserted with 2 tags in flight → next cycle all outputs 0, FIFO empty; a following ack asserts spurious_ack_o. With SDRAM_ARB_STATS_EN, counters read 0 after reset and after stats_clear_i.
